// File: rtl/up_pkg.sv
// Shared opcode and phase encodings for the up_core_param processor.
package up_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_LIT   = 4'h1,
    OP_IN    = 4'h2,
    OP_OUT   = 4'h3,
    OP_ADDI  = 4'h4,
    OP_NANDI = 4'h5,
    OP_CMPI  = 4'h6,
    OP_LD    = 4'h7,
    OP_ST    = 4'h8,
    OP_ADDM  = 4'h9,
    OP_JMP   = 4'hA,
    OP_JC    = 4'hB,
    OP_JZ    = 4'hC,
    OP_CALL  = 4'hD,
    OP_RET   = 4'hE,
    OP_HALT  = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    PH_FETCH  = 2'd0,
    PH_FETCH2 = 2'd1,
    PH_EXEC   = 2'd2
  } phase_t;

  // Long opcodes carry a second program word with the low address bits.
  function automatic logic is_long(input logic [3:0] op);
    return (op >= OP_LD) && (op <= OP_CALL);
  endfunction

endpackage

// File: rtl/up_ret_stack.sv
// Return-address stack; push on full and pop on empty are silently ignored.
module up_ret_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [2**IDX_W];
  logic [SP_W-1:0]  sp;
  logic [IDX_W-1:0] top_idx;

  assign top_idx = IDX_W'(sp - 1'b1);
  assign full    = (sp == SP_W'(DEPTH));
  assign empty   = (sp == '0);
  assign dout    = mem[top_idx];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + 1'b1;
    end else if (pop && !empty) begin
      sp <= sp - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full) begin
      mem[sp[IDX_W-1:0]] <= din;
    end
  end

endmodule

// File: rtl/up_core_param.sv
// Accumulator fetch/execute core with long-address instructions, return stack and HALT.
module up_core_param
  import up_pkg::*;
#(
  parameter int DATA_W      = 4,
  parameter int STACK_DEPTH = 4,
  localparam int ADDR_W     = 2*DATA_W + 4,
  localparam int PW         = 4 + DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] pushbuttons,
  input  logic [PW-1:0]     prog_data,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] address_RAM,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic [1:0]        phase,
  output logic [3:0]        instr,
  output logic [DATA_W-1:0] oprnd,
  output logic [DATA_W-1:0] accu,
  output logic              c_flag,
  output logic              z_flag,
  output logic [DATA_W-1:0] FF_out,
  output logic              halted,
  output logic              stack_err
);

  phase_t              state;
  logic [3:0]          fetch_op;
  logic [DATA_W-1:0]   addend;
  logic [DATA_W-1:0]   nand_r;
  logic [DATA_W:0]     sum;
  logic [ADDR_W-1:0]   ret_addr;
  logic                stk_full;
  logic                stk_empty;
  logic                do_push;
  logic                do_pop;

  assign phase     = state;
  assign ram_wdata = accu;
  assign fetch_op  = prog_data[PW-1 -: 4];

  always_comb begin
    addend = (instr == OP_ADDM) ? ram_rdata : oprnd;
    sum    = {1'b0, accu} + {1'b0, addend};
    nand_r = ~(accu & oprnd);
  end

  // CALL pushes the PC already advanced past the second word.
  assign do_push = (state == PH_EXEC) && (instr == OP_CALL) && !stk_full;
  assign do_pop  = (state == PH_EXEC) && (instr == OP_RET) && !stk_empty;

  up_ret_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_W)
  ) u_stack (
    .clock (clock),
    .reset (reset),
    .push  (do_push),
    .pop   (do_pop),
    .din   (PC),
    .dout  (ret_addr),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= PH_FETCH;
      PC          <= '0;
      address_RAM <= '0;
      ram_we      <= 1'b0;
      instr       <= '0;
      oprnd       <= '0;
      accu        <= '0;
      c_flag      <= 1'b0;
      z_flag      <= 1'b0;
      FF_out      <= '0;
      halted      <= 1'b0;
      stack_err   <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      case (state)
        PH_FETCH: begin
          if (!halted) begin
            instr <= fetch_op;
            oprnd <= prog_data[DATA_W-1:0];
            PC    <= PC + 1'b1;
            state <= is_long(fetch_op) ? PH_FETCH2 : PH_EXEC;
          end
        end
        PH_FETCH2: begin
          address_RAM <= {oprnd, prog_data};
          PC          <= PC + 1'b1;
          ram_we      <= (instr == OP_ST);
          state       <= PH_EXEC;
        end
        PH_EXEC: begin
          state <= PH_FETCH;
          case (instr)
            OP_LIT: begin
              accu   <= oprnd;
              z_flag <= (oprnd == '0);
            end
            OP_IN: begin
              accu   <= pushbuttons;
              z_flag <= (pushbuttons == '0);
            end
            OP_OUT:  FF_out <= accu;
            OP_ADDI, OP_ADDM: begin
              {c_flag, accu} <= sum;
              z_flag         <= (sum[DATA_W-1:0] == '0);
            end
            OP_NANDI: begin
              accu   <= nand_r;
              z_flag <= (nand_r == '0);
            end
            OP_CMPI: begin
              c_flag <= (accu >= oprnd);
              z_flag <= (accu == oprnd);
            end
            OP_LD: begin
              accu   <= ram_rdata;
              z_flag <= (ram_rdata == '0);
            end
            OP_JMP: PC <= address_RAM;
            OP_JC:  if (c_flag) PC <= address_RAM;
            OP_JZ:  if (z_flag) PC <= address_RAM;
            OP_CALL: begin
              if (stk_full) stack_err <= 1'b1;
              else          PC        <= address_RAM;
            end
            OP_RET: begin
              if (stk_empty) stack_err <= 1'b1;
              else           PC        <= ret_addr;
            end
            OP_HALT: halted <= 1'b1;
            default: ;
          endcase
        end
        default: state <= PH_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_up_core_param.sv
// Scoreboard bench for up_core_param: per-instruction post-EXEC state and RAM writes.
module tb_up_core_param;

  localparam int DW = 4;
  localparam int PW = 8;
  localparam int AW = 12;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] pushbuttons = '0;
  logic [PW-1:0] prog_data;
  logic [DW-1:0] ram_rdata;
  logic [AW-1:0] PC, address_RAM;
  logic [DW-1:0] ram_wdata, oprnd, accu, FF_out;
  logic          ram_we, c_flag, z_flag, halted, stack_err;
  logic [1:0]    phase;
  logic [3:0]    instr;

  logic [PW-1:0] rom [0:4095];
  logic [DW-1:0] ram [0:4095];

  typedef struct {
    string       name;
    logic [23:0] v;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] wr_q[$];
  logic [1:0]  ph_log[$];
  int          tests = 0;
  int          fails = 0;

  always #5 clock = ~clock;

  assign prog_data = rom[PC];
  assign ram_rdata = ram[address_RAM];

  always @(posedge clock) if (ram_we) ram[address_RAM] <= ram_wdata;

  up_core_param #(.DATA_W(DW), .STACK_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .pushbuttons(pushbuttons),
    .prog_data(prog_data), .ram_rdata(ram_rdata), .PC(PC),
    .address_RAM(address_RAM), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .phase(phase), .instr(instr), .oprnd(oprnd), .accu(accu),
    .c_flag(c_flag), .z_flag(z_flag), .FF_out(FF_out),
    .halted(halted), .stack_err(stack_err)
  );

  // Monitor: checks each completed instruction and every write strobe.
  initial begin
    logic [1:0]  prev;
    logic [23:0] act;
    logic [15:0] w;
    exp_t        e;
    prev = 2'd0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev = 2'd0;
      end else begin
        ph_log.push_back(phase);
        if (ram_we) begin
          tests++;
          if (wr_q.size() == 0) begin
            fails++;
            $display("FAIL ram_we_unexpected: got write addr=%h data=%h, required no write",
                     address_RAM, ram_wdata);
          end else begin
            w = wr_q.pop_front();
            if ({address_RAM, ram_wdata} !== w[15:0] || phase !== 2'd2) begin
              fails++;
              $display("FAIL ram_write: got addr=%h data=%h phase=%0d, required addr=%h data=%h phase=2",
                       address_RAM, ram_wdata, phase, w[15:4], w[3:0]);
            end
          end
        end
        if (prev == 2'd2) begin
          act = {PC, accu, c_flag, z_flag, FF_out, stack_err, halted};
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL instr_unexpected: got {pc,acc,c,z,ff,err,halt}=%h, required no instruction", act);
          end else begin
            e = exp_q.pop_front();
            if (act !== e.v) begin
              fails++;
              $display("FAIL %s: got {pc,acc,c,z,ff,err,halt}=%h, required %h", e.name, act, e.v);
            end
          end
        end
        prev = phase;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic exp(input string name, input logic [11:0] pc, input logic [3:0] a,
                     input logic c, input logic z, input logic [3:0] ff,
                     input logic err, input logic halt);
    exp_t e;
    e.name = name;
    e.v    = {pc, a, c, z, ff, err, halt};
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string name);
    chk(name, {PC, address_RAM, ram_we, phase, instr},       '0);
    chk({name, "_data"}, {oprnd, accu, c_flag, z_flag, FF_out, halted, stack_err}, '0);
  endtask

  task automatic start_prog(input string name);
    reset = 1'b1;
    #1;
    check_zero(name);
    for (int i = 0; i < 4096; i++) rom[i] = 8'hF0;
    ph_log.delete();
  endtask

  task automatic release_reset();
    @(posedge clock);
    #2 reset = 1'b0;
    chk("restart_pc", {PC, 2'b00, phase}, '0);
  endtask

  task automatic run(input string name, input int max_cycles);
    int n;
    n = 0;
    release_reset();
    while (!halted && n < max_cycles) begin
      @(negedge clock);
      n++;
    end
    chk({name, "_halt_reached"}, {31'd0, halted}, 32'd1);
    @(negedge clock);
    #1;
    chk({name, "_queues_drained"}, exp_q.size() + wr_q.size(), 0);
    exp_q.delete();
    wr_q.delete();
  endtask

  initial begin
    #1;
    // Test 1: LIT / ADDI carry / OUT / IN
    start_prog("t1_reset");
    pushbuttons = 4'hA;
    rom[0] = 8'h15; rom[1] = 8'h4C; rom[2] = 8'h30; rom[3] = 8'h20; rom[4] = 8'hF0;
    exp("t1_lit",  12'h001, 4'h5, 0, 0, 4'h0, 0, 0);
    exp("t1_addi", 12'h002, 4'h1, 1, 0, 4'h0, 0, 0);
    exp("t1_out",  12'h003, 4'h1, 1, 0, 4'h1, 0, 0);
    exp("t1_in",   12'h004, 4'hA, 1, 0, 4'h1, 0, 0);
    exp("t1_halt", 12'h005, 4'hA, 1, 0, 4'h1, 0, 1);
    run("t1", 100);
    if (ph_log.size() >= 4)
      chk("t1_phases", {ph_log[0], ph_log[1], ph_log[2], ph_log[3]}, {2'd0, 2'd2, 2'd0, 2'd2});
    else
      chk("t1_phases_len", ph_log.size(), 4);

    // Test 2: ST / LD / ADDM through RAM address 0x123
    start_prog("t2_reset");
    rom[0] = 8'h19; rom[1] = 8'h81; rom[2] = 8'h23; rom[3] = 8'h10;
    rom[4] = 8'h71; rom[5] = 8'h23; rom[6] = 8'h91; rom[7] = 8'h23; rom[8] = 8'hF0;
    exp("t2_lit9", 12'h001, 4'h9, 0, 0, 4'h0, 0, 0);
    exp("t2_st",   12'h003, 4'h9, 0, 0, 4'h0, 0, 0);
    wr_q.push_back({12'h123, 4'h9});
    exp("t2_lit0", 12'h004, 4'h0, 0, 1, 4'h0, 0, 0);
    exp("t2_ld",   12'h006, 4'h9, 0, 0, 4'h0, 0, 0);
    exp("t2_addm", 12'h008, 4'h2, 1, 0, 4'h0, 0, 0);
    exp("t2_halt", 12'h009, 4'h2, 1, 0, 4'h0, 0, 1);
    run("t2", 100);
    if (ph_log.size() >= 5)
      chk("t2_long_phases", {ph_log[2], ph_log[3], ph_log[4]}, {2'd0, 2'd1, 2'd2});
    else
      chk("t2_phases_len", ph_log.size(), 5);

    // Test 3: CMPI / JZ / JC taken and not taken, NANDI, IN zero, JMP
    start_prog("t3_reset");
    pushbuttons = 4'h0;
    rom[12'h000] = 8'h19; rom[12'h001] = 8'h69; rom[12'h002] = 8'hC0; rom[12'h003] = 8'h40;
    rom[12'h040] = 8'h13; rom[12'h041] = 8'h69; rom[12'h042] = 8'hC0; rom[12'h043] = 8'h00;
    rom[12'h044] = 8'hB0; rom[12'h045] = 8'h00; rom[12'h046] = 8'h49; rom[12'h047] = 8'h4F;
    rom[12'h048] = 8'hB0; rom[12'h049] = 8'h60;
    rom[12'h060] = 8'h56; rom[12'h061] = 8'h20; rom[12'h062] = 8'hA0; rom[12'h063] = 8'h70;
    exp("t3_lit9",    12'h001, 4'h9, 0, 0, 4'h0, 0, 0);
    exp("t3_cmpi_eq", 12'h002, 4'h9, 1, 1, 4'h0, 0, 0);
    exp("t3_jz_take", 12'h040, 4'h9, 1, 1, 4'h0, 0, 0);
    exp("t3_lit3",    12'h041, 4'h3, 1, 0, 4'h0, 0, 0);
    exp("t3_cmpi_lt", 12'h042, 4'h3, 0, 0, 4'h0, 0, 0);
    exp("t3_jz_skip", 12'h044, 4'h3, 0, 0, 4'h0, 0, 0);
    exp("t3_jc_skip", 12'h046, 4'h3, 0, 0, 4'h0, 0, 0);
    exp("t3_addi9",   12'h047, 4'hC, 0, 0, 4'h0, 0, 0);
    exp("t3_addiF",   12'h048, 4'hB, 1, 0, 4'h0, 0, 0);
    exp("t3_jc_take", 12'h060, 4'hB, 1, 0, 4'h0, 0, 0);
    exp("t3_nandi",   12'h061, 4'hD, 1, 0, 4'h0, 0, 0);
    exp("t3_in_zero", 12'h062, 4'h0, 1, 1, 4'h0, 0, 0);
    exp("t3_jmp",     12'h070, 4'h0, 1, 1, 4'h0, 0, 0);
    exp("t3_halt",    12'h071, 4'h0, 1, 1, 4'h0, 0, 1);
    run("t3", 200);

    // Test 4a: CALL/RET round trip, then RET on empty stack
    start_prog("t4a_reset");
    rom[12'h000] = 8'hA0; rom[12'h001] = 8'h10;
    rom[12'h010] = 8'hD0; rom[12'h011] = 8'h80; rom[12'h012] = 8'hE0; rom[12'h013] = 8'hF0;
    rom[12'h080] = 8'hE0;
    exp("t4a_jmp",       12'h010, 4'h0, 0, 0, 4'h0, 0, 0);
    exp("t4a_call",      12'h080, 4'h0, 0, 0, 4'h0, 0, 0);
    exp("t4a_ret",       12'h012, 4'h0, 0, 0, 4'h0, 0, 0);
    exp("t4a_ret_empty", 12'h013, 4'h0, 0, 0, 4'h0, 1, 0);
    exp("t4a_halt",      12'h014, 4'h0, 0, 0, 4'h0, 1, 1);
    run("t4a", 100);

    // Test 4b: one more nested CALL than the stack holds
    start_prog("t4b_reset");
    rom[0] = 8'hD0; rom[1] = 8'h02; rom[2] = 8'hD0; rom[3] = 8'h04;
    rom[4] = 8'hD0; rom[5] = 8'h06; rom[6] = 8'hD0; rom[7] = 8'h08;
    rom[8] = 8'hD0; rom[9] = 8'h0A;
    exp("t4b_call1",     12'h002, 4'h0, 0, 0, 4'h0, 0, 0);
    exp("t4b_call2",     12'h004, 4'h0, 0, 0, 4'h0, 0, 0);
    exp("t4b_call3",     12'h006, 4'h0, 0, 0, 4'h0, 0, 0);
    exp("t4b_call4",     12'h008, 4'h0, 0, 0, 4'h0, 0, 0);
    exp("t4b_call_full", 12'h00A, 4'h0, 0, 0, 4'h0, 1, 0);
    exp("t4b_halt",      12'h00B, 4'h0, 0, 0, 4'h0, 1, 1);
    run("t4b", 100);

    // Test 5: PC wrap from 0xFFF, then HALT freeze
    start_prog("t5_reset");
    rom[12'h000] = 8'hB0; rom[12'h001] = 8'h10; rom[12'h002] = 8'h1F; rom[12'h003] = 8'h41;
    rom[12'h004] = 8'hAF; rom[12'h005] = 8'hFE;
    rom[12'hFFE] = 8'h00; rom[12'hFFF] = 8'h00;
    exp("t5_jc_skip", 12'h002, 4'h0, 0, 0, 4'h0, 0, 0);
    exp("t5_litF",    12'h003, 4'hF, 0, 0, 4'h0, 0, 0);
    exp("t5_addi1",   12'h004, 4'h0, 1, 1, 4'h0, 0, 0);
    exp("t5_jmp",     12'hFFE, 4'h0, 1, 1, 4'h0, 0, 0);
    exp("t5_nop",     12'hFFF, 4'h0, 1, 1, 4'h0, 0, 0);
    exp("t5_nop_wrap",12'h000, 4'h0, 1, 1, 4'h0, 0, 0);
    exp("t5_jc_take", 12'h010, 4'h0, 1, 1, 4'h0, 0, 0);
    exp("t5_halt",    12'h011, 4'h0, 1, 1, 4'h0, 0, 1);
    run("t5", 100);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      #1;
      chk("t5_frozen", {PC, 2'b00, phase, 3'b000, halted, 3'b000, ram_we}, {12'h011, 4'h0, 4'h1, 4'h0});
    end

    // Test 6: async reset during FETCH2 of ST, then clean restart
    start_prog("t6_reset");
    rom[0] = 8'h19; rom[1] = 8'h81; rom[2] = 8'h23; rom[3] = 8'hF0;
    exp("t6_pre_lit9", 12'h001, 4'h9, 0, 0, 4'h0, 0, 0);
    release_reset();
    begin
      int n;
      n = 0;
      while (phase != 2'd1 && n < 50) begin
        @(negedge clock);
        n++;
      end
      chk("t6_reached_fetch2", {30'd0, phase}, 32'd1);
    end
    #1 reset = 1'b1;
    #1 check_zero("t6_async_clear");
    @(posedge clock);
    #1 chk("t6_no_we_in_reset", {31'd0, ram_we}, 32'd0);
    chk("t6_pre_drained", exp_q.size(), 0);
    exp("t6_lit9", 12'h001, 4'h9, 0, 0, 4'h0, 0, 0);
    exp("t6_st",   12'h003, 4'h9, 0, 0, 4'h0, 0, 0);
    wr_q.push_back({12'h123, 4'h9});
    exp("t6_halt", 12'h004, 4'h9, 0, 0, 4'h0, 0, 1);
    run("t6", 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule

// File: doc/up_core_param.md
Name: up_core_param

Overview:
Parametrised successor of the team's 4-bit accumulator microprocessor. Fetch/execute core with external program memory and data RAM, a pushbutton input port and a latched output port. Adds over the previous generation:
- generic data width
- two-word (long) instructions carrying a full address
- a hardware return stack for CALL/RET with sticky error reporting
- HALT

Sits between the board-level program ROM/RAM and the I/O pins.

Parameters:
DATA_W, 4, accumulator/operand/RAM data width; program word PW = 4+DATA_W
STACK_DEPTH, 4, return-stack entries (>=1)
ADDR_W, 2*DATA_W+4 (localparam, 12 at default), PC and RAM address width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
pushbuttons  in  DATA_W  input port sampled by IN
prog_data  in  PW  program word at PC (combinational ROM read)
ram_rdata  in  DATA_W  RAM read data (combinational read of ram_addr)
PC  out  ADDR_W  program counter, drives ROM address
address_RAM  out  ADDR_W  RAM address, registered
ram_wdata  out  DATA_W  equals accu
ram_we  out  1  write strobe, high only in EXEC of ST
phase  out  2  0=FETCH, 1=FETCH2, 2=EXEC
instr  out  4  latched opcode
oprnd  out  DATA_W  latched operand
accu  out  DATA_W  accumulator
c_flag, z_flag  out  1  carry/zero flags
FF_out  out  DATA_W  output port register
halted  out  1  core stopped by HALT
stack_err  out  1  sticky: CALL on full or RET on empty

Behaviour:
- Reset (async, high) forces:
  - PC=0, phase=FETCH
  - instr, oprnd, accu, FF_out, address_RAM = 0
  - c_flag, z_flag, halted, stack_err = 0
  - stack pointer = 0, ram_we=0
  - Mid-instruction reset aborts it with no RAM write.
- FETCH:
  - {instr,oprnd} <= prog_data; PC <= PC+1.
  - Next state is FETCH2 if the opcode is long (7,8,9,A,B,C,D), else EXEC.
- FETCH2:
  - address_RAM <= {oprnd, prog_data}; PC <= PC+1; next state EXEC.
- EXEC:
  - Perform the opcode, then return to FETCH.
  - Short instructions take 2 cycles; long instructions take 3.
- PC arithmetic is modulo 2^ADDR_W; increment from all-ones wraps to 0.
- Opcodes ("tgt" = address_RAM):
  - 0 NOP.
  - 1 LIT: accu=oprnd.
  - 2 IN: accu=pushbuttons.
  - 3 OUT: FF_out=accu.
  - 4 ADDI: {c,accu}=accu+oprnd.
  - 5 NANDI: accu=~(accu&oprnd).
  - 6 CMPI: c=(accu>=oprnd) unsigned, z=(accu==oprnd); accu unchanged.
  - 7 LD: accu=ram_rdata.
  - 8 ST: ram_we=1 for this cycle only.
  - 9 ADDM: {c,accu}=accu+ram_rdata.
  - A JMP: PC=tgt.
  - B JC: PC=tgt if c_flag.
  - C JZ: PC=tgt if z_flag.
  - D CALL: push return address (current PC, already past word 2), then PC=tgt.
  - E RET: PC=pop.
  - F HALT: halted=1.
- Flag updates:
  - z = (new accu==0) for 1,2,4,5,7,9.
  - c changes only on 4, 6, 9.
  - All other opcodes leave flags unchanged.
- Width: sums are DATA_W+1 bits; the carry is the MSB.
- Stack:
  - CALL with sp==STACK_DEPTH: no push, no jump (falls through), stack_err=1.
  - RET with sp==0: behaves as NOP, stack_err=1.
  - stack_err clears only on reset.
- Halted:
  - phase stays FETCH and PC, registers and flags are frozen until reset.
  - No fetch, no ram_we.

Decomposition:
- Package up_pkg: opcode constants OP_NOP..OP_HALT, phase encodings PH_FETCH/PH_FETCH2/PH_EXEC, function is_long(opcode).
- Sub-module up_ret_stack (parameter DEPTH, WIDTH):
  - Inputs: push, pop, din.
  - Outputs: dout, full, empty.
  - Same clock and asynchronous active-high reset.
  - Push on full and pop on empty are ignored internally.

Test Plan:
1. Reset then LIT 5; ADDI 0xC; OUT -> accu=0x1 and c=1 after ADDI; FF_out=0x1. Phases cycle 0,2,0,2; PC=3.
2. ST: LIT 9; ST 0x1,0x23 -> in EXEC address_RAM=0x123, ram_we=1 for one clock, ram_wdata=9. Long instruction occupies phases 0,1,2.
3. CMPI 9 with accu=9, then JZ 0x0,0x40 -> z=1, c=1; PC=0x040. Repeat with accu=3 -> no jump, PC sequential.
4. CALL 0x0,0x80 at PC=0x010, then RET at 0x080 -> PC=0x080, then PC=0x012. STACK_DEPTH+1 nested CALLs -> last one falls through and stack_err=1.
5. PC reaches 0xFFF with NOP -> next fetch at 0x000. HALT -> halted=1 and PC frozen for 10 clocks.
6. Assert reset asynchronously in FETCH2 of ST -> all outputs 0 immediately, no ram_we pulse. Release reset -> fetch restarts at PC=0.
